// File: rtl/beverage_dispenser_ctrl.sv
// Drink dispenser controller: coin credit, price check and change, then timed
// sequencing of ingredient valves (one at a time, index 0 first).
module beverage_dispenser_ctrl #(
  parameter int NUM_RECIPES   = 4,
  parameter int NUM_INGR      = 5,
  parameter int CREDIT_W      = 5,
  parameter int MAX_CREDIT    = 20,
  parameter int DUR_W         = 3,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter logic [NUM_RECIPES*CREDIT_W-1:0] PRICE_TABLE = {NUM_RECIPES{CREDIT_W'(3)}},
  parameter logic [NUM_RECIPES*NUM_INGR*DUR_W-1:0] DUR_TABLE =
    {(NUM_RECIPES*NUM_INGR){DUR_W'(1)}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_100,
  input  logic                coin_500,
  input  logic [((NUM_RECIPES > 1) ? $clog2(NUM_RECIPES) : 1)-1:0] recipe_sel,
  input  logic                confirm,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic [NUM_INGR-1:0] ingredient_on,
  output logic                busy,
  output logic                coin_reject,
  output logic                error,
  output logic                finished
);

  localparam int SEL_W  = (NUM_RECIPES > 1) ? $clog2(NUM_RECIPES) : 1;
  localparam int IDX_W  = (NUM_INGR > 1) ? $clog2(NUM_INGR) : 1;
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DISPENSE, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                error_q, error_d;
  logic [IDX_W-1:0]    ingr_idx_q, ingr_idx_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DUR_W-1:0]    sec_q, sec_d;
  logic [SEL_W-1:0]    recipe_q, recipe_d;

  logic [CREDIT_W:0]   coin_add;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [DUR_W-1:0]    cur_dur;
  logic                coin_any;
  logic                advance;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] sel);
    price_of = '0;
    for (int r = 0; r < NUM_RECIPES; r++)
      if (sel == SEL_W'(r)) price_of = PRICE_TABLE[r*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic valid_sel(input logic [SEL_W-1:0] sel);
    valid_sel = 1'b0;
    for (int r = 0; r < NUM_RECIPES; r++)
      if (sel == SEL_W'(r)) valid_sel = 1'b1;
  endfunction

  function automatic logic [DUR_W-1:0] dur_of(input logic [SEL_W-1:0] rcp,
                                              input logic [IDX_W-1:0] idx);
    dur_of = '0;
    for (int r = 0; r < NUM_RECIPES; r++)
      for (int i = 0; i < NUM_INGR; i++)
        if (rcp == SEL_W'(r) && idx == IDX_W'(i))
          dur_of = DUR_TABLE[(r*NUM_INGR+i)*DUR_W +: DUR_W];
  endfunction

  always_comb begin
    coin_add = '0;
    if (coin_100) coin_add = coin_add + (CREDIT_W+1)'(1);
    if (coin_500) coin_add = coin_add + (CREDIT_W+1)'(5);
    coin_sum  = {1'b0, credit_q} + coin_add;
    coin_any  = coin_100 | coin_500;
    sel_price = price_of(recipe_sel);
    sel_ok    = valid_sel(recipe_sel);
    cur_dur   = dur_of(recipe_q, ingr_idx_q);
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    change_valid_d = change_valid_q;
    coin_reject_d  = 1'b0;
    error_d        = 1'b0;
    ingr_idx_d     = ingr_idx_q;
    tick_d         = tick_q;
    sec_d          = sec_q;
    recipe_d       = recipe_q;
    advance        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (confirm) begin
          // Coins colliding with a confirm are never credited, refused or not.
          coin_reject_d = coin_any;
          if (!sel_ok || credit_q < sel_price) begin
            error_d = 1'b1;
          end else begin
            change_d       = credit_q - sel_price;
            change_valid_d = 1'b1;
            credit_d       = '0;
            recipe_d       = recipe_sel;
            ingr_idx_d     = '0;
            tick_d         = '0;
            sec_d          = '0;
            state_d        = ST_DISPENSE;
          end
        end else if (cancel) begin
          coin_reject_d  = coin_any;
          change_d       = credit_q;
          change_valid_d = (credit_q != '0);
          credit_d       = '0;
        end else if (coin_any) begin
          if (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d       = coin_sum[CREDIT_W-1:0];
            change_d       = '0;
            change_valid_d = 1'b0;
          end
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin_any;
        if (cur_dur == '0) begin
          advance = 1'b1;
        end else if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
          tick_d = '0;
          if (sec_q == cur_dur - DUR_W'(1)) advance = 1'b1;
          else sec_d = sec_q + DUR_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
        // Prescaler and second count restart with every ingredient.
        if (advance) begin
          tick_d = '0;
          sec_d  = '0;
          if (ingr_idx_q == IDX_W'(NUM_INGR - 1)) state_d = ST_DONE;
          else ingr_idx_d = ingr_idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        coin_reject_d = coin_any;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      error_q        <= 1'b0;
      ingr_idx_q     <= '0;
      tick_q         <= '0;
      sec_q          <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      error_q        <= error_d;
      ingr_idx_q     <= ingr_idx_d;
      tick_q         <= tick_d;
      sec_q          <= sec_d;
    end
  end

  always_ff @(posedge clock) begin
    recipe_q <= recipe_d;
  end

  assign credit        = credit_q;
  assign change        = change_q;
  assign change_valid  = change_valid_q;
  assign coin_reject   = coin_reject_q;
  assign error         = error_q;
  assign busy          = (state_q != ST_IDLE);
  assign finished      = (state_q == ST_DONE);
  assign ingredient_on = (state_q == ST_DISPENSE && cur_dur != '0) ?
                         (NUM_INGR'(1) << ingr_idx_q) : '0;

endmodule

// File: tb/tb_beverage_dispenser_ctrl.sv
// Directed bench for beverage_dispenser_ctrl: coins, saturation, cancel,
// refused confirms, a full timed brew and a reset that aborts a brew.
module tb_beverage_dispenser_ctrl;

  localparam int TPS = 4;
  localparam logic [19:0] PRICES  = {5'd3, 5'd3, 5'd6, 5'd3};
  localparam logic [59:0] DURS    = {{10{3'd1}}, 3'd3, 3'd0, 3'd1, 3'd0, 3'd2, {5{3'd1}}};
  localparam logic [14:0] PRICES3 = {5'd3, 5'd6, 5'd3};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_100 = 1'b0, coin_500 = 1'b0, confirm = 1'b0, cancel = 1'b0;
  logic       confirm3 = 1'b0;
  logic [1:0] recipe_sel = 2'd0;

  logic [4:0] credit, change, ingredient_on;
  logic       change_valid, busy, coin_reject, error, finished;
  logic [4:0] credit3, change3, ingredient_on3;
  logic       change_valid3, busy3, coin_reject3, error3, finished3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  beverage_dispenser_ctrl #(
    .NUM_RECIPES(4), .NUM_INGR(5), .CREDIT_W(5), .MAX_CREDIT(20), .DUR_W(3),
    .TICKS_PER_SEC(TPS), .PRICE_TABLE(PRICES), .DUR_TABLE(DURS)
  ) u_dut (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .recipe_sel(recipe_sel), .confirm(confirm), .cancel(cancel),
    .credit(credit), .change(change), .change_valid(change_valid),
    .ingredient_on(ingredient_on), .busy(busy), .coin_reject(coin_reject),
    .error(error), .finished(finished)
  );

  beverage_dispenser_ctrl #(
    .NUM_RECIPES(3), .NUM_INGR(5), .CREDIT_W(5), .MAX_CREDIT(20), .DUR_W(3),
    .TICKS_PER_SEC(TPS), .PRICE_TABLE(PRICES3)
  ) u_dut3 (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .recipe_sel(recipe_sel), .confirm(confirm3), .cancel(1'b0),
    .credit(credit3), .change(change3), .change_valid(change_valid3),
    .ingredient_on(ingredient_on3), .busy(busy3), .coin_reject(coin_reject3),
    .error(error3), .finished(finished3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of pulses on a falling edge; returns on the next falling
  // edge, when the registered response is visible.
  task automatic pulse(input logic c1, input logic c5, input logic cf, input logic cn);
    @(negedge clock);
    coin_100 = c1; coin_500 = c5; confirm = cf; cancel = cn;
    @(negedge clock);
    coin_100 = 1'b0; coin_500 = 1'b0; confirm = 1'b0; cancel = 1'b0;
  endtask

  function automatic logic [4:0] exp_valves(input int k);
    if (k <= 8)       return 5'b00001;
    else if (k == 9)  return 5'b00000;
    else if (k <= 13) return 5'b00100;
    else if (k == 14) return 5'b00000;
    else              return 5'b10000;
  endfunction

  initial begin
    int fin_seen;

    // Reset held with coins pulsing
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      coin_500 = ~coin_500;
      coin_100 = 1'b1;
    end
    @(negedge clock);
    chk("rst_credit", credit, 0);
    chk("rst_change", change, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_valves", ingredient_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_error", error, 0);
    chk("rst_finished", finished, 0);
    coin_100 = 1'b0; coin_500 = 1'b0;
    reset = 1'b1;

    // Coins and saturation
    pulse(0, 1, 0, 0); chk("coin500", credit, 5);
    pulse(1, 1, 0, 0); chk("coin_both", credit, 11);
    pulse(0, 1, 0, 0); chk("coin500_b", credit, 16);
    pulse(0, 1, 0, 0); chk("sat_reject", coin_reject, 1); chk("sat_credit", credit, 16);
    @(negedge clock);  chk("reject_1cyc", coin_reject, 0);
    repeat (4) pulse(1, 0, 0, 0);
    chk("credit_max", credit, 20); chk("at_max_noreject", coin_reject, 0);
    pulse(1, 0, 0, 0); chk("over_max_reject", coin_reject, 1); chk("over_max_credit", credit, 20);

    // Cancel refunds
    pulse(0, 0, 0, 1);
    chk("cancel20_change", change, 20); chk("cancel20_cv", change_valid, 1);
    chk("cancel20_credit", credit, 0);
    pulse(0, 1, 0, 0); chk("coin_clears_cv", change_valid, 0); chk("coin_clears_chg", change, 0);
    repeat (2) pulse(1, 0, 0, 0);
    chk("credit7", credit, 7);
    pulse(0, 0, 0, 1);
    chk("cancel7_change", change, 7); chk("cancel7_cv", change_valid, 1);
    chk("cancel7_credit", credit, 0);
    pulse(1, 0, 0, 0); chk("after_cancel_cv", change_valid, 0); chk("after_cancel_credit", credit, 1);
    pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
    chk("cancel_zero_cv", change_valid, 0); chk("cancel_zero_change", change, 0);

    // Insufficient credit
    pulse(0, 1, 0, 0);
    recipe_sel = 2'd1;
    pulse(0, 0, 1, 0);
    chk("poor_error", error, 1); chk("poor_credit", credit, 5); chk("poor_busy", busy, 0);
    @(negedge clock); chk("error_1cyc", error, 0);

    // Full brew of recipe 1 with credit 8
    repeat (3) pulse(1, 0, 0, 0);
    chk("credit8", credit, 8);
    @(negedge clock); confirm = 1'b1;
    @(negedge clock); confirm = 1'b0;
    chk("brew_change", change, 2); chk("brew_cv", change_valid, 1);
    chk("brew_credit", credit, 0); chk("brew_busy", busy, 1);
    fin_seen = 0;
    for (int k = 1; k <= 26; k++) begin
      chk($sformatf("valves_k%0d", k), ingredient_on, exp_valves(k));
      if (finished) fin_seen++;
      if (k == 4) begin
        chk("brew_coin_reject", coin_reject, 1); chk("brew_coin_credit", credit, 0);
      end
      coin_100 = (k == 3);
      @(negedge clock);
    end
    chk("no_early_finish", fin_seen, 0);
    chk("finished_pulse", finished, 1); chk("done_valves", ingredient_on, 0);
    chk("done_busy", busy, 1);
    @(negedge clock);
    chk("finished_1cyc", finished, 0); chk("idle_busy", busy, 0);
    chk("change_persist", change, 2); chk("cv_persist", change_valid, 1);

    // Out-of-range selection on the three-recipe instance
    recipe_sel = 2'd3;
    @(negedge clock); confirm3 = 1'b1;
    @(negedge clock); confirm3 = 1'b0;
    chk("bad_sel_error", error3, 1); chk("bad_sel_busy", busy3, 0);

    // Reset during ingredient 0 aborts the brew
    recipe_sel = 2'd1;
    pulse(1, 1, 0, 0);
    chk("credit6", credit, 6);
    pulse(0, 0, 1, 0);
    chk("abort_started", ingredient_on, 5'b00001);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_valves", ingredient_on, 0); chk("abort_busy", busy, 0);
    chk("abort_cv", change_valid, 0); chk("abort_change", change, 0);
    reset = 1'b1;
    fin_seen = 0;
    repeat (32) begin
      @(negedge clock);
      if (finished || busy) fin_seen++;
    end
    chk("abort_no_finish", fin_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
